// File: rtl/rom_read_arbiter_pkg.sv
// Shared definitions for rom_read_arbiter: default widths, memory depth, FSM states, requester IDs.
// ROM_ADDR_CHECK_EN (when defined) enables out-of-range address detection in the top.
package rom_read_arbiter_pkg;

  localparam int DEF_ADDR_W = 27;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 35661;
  localparam int DEF_LEN_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/rom_read_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: the requester that did not win last time
// takes a tie, a lone requester always wins.
module rr_arb2
  import rom_read_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = ~rr_last;
    end else if (req1) begin
      winner = REQ_ID1;
    end else begin
      winner = REQ_ID0;
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin burst read arbiter in front of a single combinational-read lookup memory.
// Optional ROM_ADDR_CHECK_EN adds rerr0/rerr1 and suppresses reads at addresses >= DEPTH.
module rom_read_arbiter
  import rom_read_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [LEN_W-1:0]  len0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
`ifdef ROM_ADDR_CHECK_EN
  output logic              rerr0,
  output logic              rerr1,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_readE,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  // Handshake: a requester holds req/addr/len until it sees its one-cycle gnt, then
  // drops req that same cycle; words return on rvalid with no back-pressure.

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_check
    $error("DEPTH does not fit the address width");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr, next_addr, start_addr;
  logic [LEN_W-1:0]    remaining, start_len;
  logic                owner, rr_last;
  logic                pick, pick_valid;
  logic                start_ok, next_ok, cur_oob;
  logic [DATA_W-1:0]   word;

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .rr_last (rr_last),
    .winner  (pick),
    .valid   (pick_valid)
  );

  assign start_addr = pick ? addr1 : addr0;
  assign start_len  = pick ? len1 : len0;
  assign next_addr  = cur_addr + ADDR_W'(1);

`ifdef ROM_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  assign start_ok = (start_addr < DEPTH_A);
  assign next_ok  = (next_addr < DEPTH_A);
  assign cur_oob  = (cur_addr >= DEPTH_A);
`else
  assign start_ok = 1'b1;
  assign next_ok  = 1'b1;
  assign cur_oob  = 1'b0;
`endif

  assign word = cur_oob ? '0 : mem_data;
  assign busy = (state_q == ST_READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_READ;
      ST_READ: if (remaining == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // mem_address/mem_readE are loaded one edge ahead so the memory sees cur_addr
  // during every READ cycle and the word is captured on that cycle's closing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_address <= '0;
      mem_readE   <= 1'b0;
      cur_addr    <= '0;
      remaining   <= '0;
      owner       <= REQ_ID0;
      rr_last     <= REQ_ID1;
`ifdef ROM_ADDR_CHECK_EN
      rerr0       <= 1'b0;
      rerr1       <= 1'b0;
`endif
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
`ifdef ROM_ADDR_CHECK_EN
      rerr0   <= 1'b0;
      rerr1   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt0        <= (pick == REQ_ID0);
            gnt1        <= (pick == REQ_ID1);
            rr_last     <= pick;
            owner       <= pick;
            cur_addr    <= start_addr;
            remaining   <= start_len;
            mem_address <= start_addr;
            mem_readE   <= start_ok;
          end
        end
        ST_READ: begin
          if (owner == REQ_ID1) begin
            rdata1  <= word;
            rvalid1 <= 1'b1;
`ifdef ROM_ADDR_CHECK_EN
            rerr1   <= cur_oob;
`endif
          end else begin
            rdata0  <= word;
            rvalid0 <= 1'b1;
`ifdef ROM_ADDR_CHECK_EN
            rerr0   <= cur_oob;
`endif
          end
          cur_addr <= next_addr;
          if (remaining == '0) begin
            mem_address <= '0;
            mem_readE   <= 1'b0;
          end else begin
            remaining   <= remaining - LEN_W'(1);
            mem_address <= next_addr;
            mem_readE   <= next_ok;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Randomized scoreboard bench for rom_read_arbiter: the driver predicts each burst
// from the arbitration rules and queues the expected words; a monitor checks outputs.
module tb_rom_read_arbiter;

  localparam int AW    = 27;
  localparam int DW    = 32;
  localparam int LW    = 2;
  localparam int DEPTH = 35661;
  localparam int EW    = DW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [LW-1:0] len0, len1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          rerr0, rerr1;
  logic [AW-1:0] mem_address;
  logic          mem_readE;
  logic [DW-1:0] mem_data;
  logic          busy;

  always #5 clk = ~clk;

  rom_read_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .addr0       (addr0),
    .len0        (len0),
    .gnt0        (gnt0),
    .rvalid0     (rvalid0),
    .rdata0      (rdata0),
    .req1        (req1),
    .addr1       (addr1),
    .len1        (len1),
    .gnt1        (gnt1),
    .rvalid1     (rvalid1),
    .rdata1      (rdata1),
`ifdef ROM_ADDR_CHECK_EN
    .rerr0       (rerr0),
    .rerr1       (rerr1),
`endif
    .mem_address (mem_address),
    .mem_readE   (mem_readE),
    .mem_data    (mem_data),
    .busy        (busy)
  );

`ifndef ROM_ADDR_CHECK_EN
  assign rerr0 = 1'b0;
  assign rerr1 = 1'b0;
`endif

  // Memory contents: odd-constant multiply keeps every address distinct.
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    logic [DW-1:0] x;
    x = {{(DW-AW){1'b0}}, a};
    return (x * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  function automatic logic oob(input logic [AW-1:0] a);
`ifdef ROM_ADDR_CHECK_EN
    return (a >= AW'(DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  assign mem_data = mem_readE ? mem_f(mem_address) : '0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [0:0]    exp_gnt_q[$];
  logic [LW-1:0] exp_len_q[$];

  logic rr_m   = 1'b1;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_burst(input logic id, input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic [AW-1:0] wa;
    logic [EW-1:0] w;
    exp_gnt_q.push_back(id);
    exp_len_q.push_back(l);
    for (int i = 0; i <= int'(l); i++) begin
      wa = a + AW'(i);
      w  = oob(wa) ? {1'b1, {DW{1'b0}}} : {1'b0, mem_f(wa)};
      exp_addr_q.push_back(wa);
      if (id) exp1_q.push_back(w);
      else    exp0_q.push_back(w);
    end
  endtask

  // Monitor: per-cycle timing model driven by observed grants plus queued expectations.
  int            beats_left = 0;
  int            busy_left  = 0;
  logic          beat_owner = 1'b0;
  logic          prev_busy  = 1'b0;
  logic          exp_busy;
  logic [EW-1:0] want;
  logic [AW-1:0] want_a;
  logic [0:0]    want_id;
  logic [LW-1:0] want_len;

  always @(negedge clk) begin
    if (!mon_en) begin
      beats_left = 0;
      busy_left  = 0;
      prev_busy  = 1'b0;
    end else begin
      check("rvalid0", rvalid0, beats_left > 0 && beat_owner == 1'b0);
      check("rvalid1", rvalid1, beats_left > 0 && beat_owner == 1'b1);
      if (rvalid0) begin
        if (exp0_q.size() == 0) check("rdata0_unexpected", 1, 0);
        else begin
          want = exp0_q.pop_front();
          check("rdata0", {rerr0, rdata0}, want);
        end
      end
      if (rvalid1) begin
        if (exp1_q.size() == 0) check("rdata1_unexpected", 1, 0);
        else begin
          want = exp1_q.pop_front();
          check("rdata1", {rerr1, rdata1}, want);
        end
      end
      if (beats_left > 0) beats_left--;

      exp_busy = gnt0 || gnt1 || busy_left > 0;
      check("busy", busy, exp_busy);
      if (exp_busy) begin
        if (exp_addr_q.size() == 0) check("addr_unexpected", 1, 0);
        else begin
          want_a = exp_addr_q.pop_front();
          check("mem_address", mem_address, want_a);
          check("mem_readE", mem_readE, !oob(want_a));
        end
      end else begin
        check("idle_mem", {mem_readE, mem_address}, 0);
      end
      if (busy_left > 0) busy_left--;

      if (gnt0 || gnt1) begin
        check("gnt_onehot", gnt0 && gnt1, 0);
        check("gnt_gap", prev_busy, 0);
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", 1, 0);
        else begin
          want_id  = exp_gnt_q.pop_front();
          want_len = exp_len_q.pop_front();
          check("gnt_id", gnt1, want_id);
          beats_left = int'(want_len) + 1;
          busy_left  = int'(want_len);
          beat_owner = want_id;
        end
      end
      prev_busy = exp_busy;
    end
  end

  task automatic drain();
    for (int t = 0; t < 30 && (exp0_q.size() != 0 || exp1_q.size() != 0); t++) tick();
    check("drain", exp0_q.size() + exp1_q.size(), 0);
  endtask

  // One or two simultaneous requests; the model decides the order.
  task automatic run_pair(input logic do0, input logic [AW-1:0] a0, input logic [LW-1:0] l0,
                          input logic do1, input logic [AW-1:0] a1, input logic [LW-1:0] l1);
    logic          first;
    logic [LW-1:0] first_len;
    int            t_first, t_second, n;
    first = (do0 && do1) ? ~rr_m : do1;
    if (first) push_burst(1'b1, a1, l1);
    else       push_burst(1'b0, a0, l0);
    if (do0 && do1) begin
      if (first) push_burst(1'b0, a0, l0);
      else       push_burst(1'b1, a1, l1);
      rr_m = ~first;
    end else begin
      rr_m = first;
    end
    first_len = first ? l1 : l0;
    req0 = do0; addr0 = a0; len0 = l0;
    req1 = do1; addr1 = a1; len1 = l1;
    n = 0; t_first = -1; t_second = -1;
    for (int t = 0; t < 60 && (req0 || req1); t++) begin
      tick();
      if (gnt0 || gnt1) begin
        n++;
        if (n == 1) t_first = t;
        else        t_second = t;
      end
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end
    if (req0 || req1) begin
      check("gnt_timeout", 1, 0);
      req0 = 1'b0;
      req1 = 1'b0;
    end
    check("gnt_latency", t_first, 0);
    if (do0 && do1) check("second_gnt_spacing", t_second - t_first, int'(first_len) + 2);
    drain();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return AW'(DEPTH - 3 + $urandom_range(0, 5));
      1:       return AW'((1 << AW) - 1 - $urandom_range(0, 3));
      2:       return AW'($urandom_range(0, 4095));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a0, a1;
    int            n, last_t;
    logic          id;
    reset = 1'b1;
    req0 = 1'b0; addr0 = '0; len0 = '0;
    req1 = 1'b0; addr1 = '0; len1 = '0;
    tick();
    tick();
    check("reset_ctrl", {gnt0, gnt1, rvalid0, rvalid1, mem_readE, busy, mem_address}, 0);
    check("reset_rdata0", rdata0, 0);
    check("reset_rdata1", rdata1, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    run_pair(1'b1, AW'(100), 2'd0, 1'b0, '0, '0);
    run_pair(1'b0, '0, '0, 1'b1, AW'(2000), 2'd3);

    // Continuous dual requests: grants alternate, exactly two cycles apart.
    a0 = rand_addr();
    a1 = rand_addr();
    for (int k = 0; k < 6; k++) begin
      id = ~rr_m;
      push_burst(id, id ? a1 : a0, 2'd0);
      rr_m = id;
    end
    req0 = 1'b1; addr0 = a0; len0 = 2'd0;
    req1 = 1'b1; addr1 = a1; len1 = 2'd0;
    n = 0; last_t = 0;
    for (int t = 0; t < 80 && n < 6; t++) begin
      tick();
      if (gnt0 || gnt1) begin
        n++;
        if (n > 1) check("alt_spacing", t - last_t, 2);
        last_t = t;
        if (n == 6) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    check("alt_count", n, 6);
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    run_pair(1'b1, AW'((1 << AW) - 2), 2'd3, 1'b0, '0, '0);

    // Reset during the second READ cycle of a 4-word burst.
    a0 = rand_addr();
    push_burst(1'b0, a0, 2'd3);
    rr_m = 1'b0;
    req0 = 1'b1; addr0 = a0; len0 = 2'd3;
    n = 0;
    for (int t = 0; t < 10 && n == 0; t++) begin
      tick();
      if (gnt0) n = 1;
    end
    check("reset_test_gnt", n, 1);
    req0 = 1'b0;
    tick();
    reset = 1'b1;
    mon_en = 1'b0;
    exp0_q.delete(); exp1_q.delete(); exp_addr_q.delete();
    exp_gnt_q.delete(); exp_len_q.delete();
    tick();
    check("midreset_ctrl", {gnt0, gnt1, rvalid0, rvalid1, mem_readE, busy, mem_address}, 0);
    check("midreset_rdata0", rdata0, 0);
    check("midreset_rdata1", rdata1, 0);
    reset = 1'b0;
    rr_m = 1'b1;
    mon_en = 1'b1;
    tick();
    run_pair(1'b0, '0, '0, 1'b1, rand_addr(), LW'($urandom_range(0, 3)));
    run_pair(1'b1, rand_addr(), 2'd1, 1'b1, rand_addr(), 2'd2);

`ifdef ROM_ADDR_CHECK_EN
    run_pair(1'b1, AW'(35659), 2'd3, 1'b0, '0, '0);
`endif

    for (int k = 0; k < 30; k++) begin
      logic d0, d1;
      d0 = 1'($urandom_range(0, 1));
      d1 = d0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_pair(d0, rand_addr(), LW'($urandom_range(0, 3)),
               d1, rand_addr(), LW'($urandom_range(0, 3)));
    end

    tick();
    tick();
    check("final_queues", exp_addr_q.size() + exp_gnt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
